// File: rtl/mul_unit_pkg.sv
// Shared definitions for the RV32M iterative multiplier: ALU-select codes,
// multiplier state encodings and the decode helper for the multiply group.
package mul_unit_pkg;

  localparam int ALUSEL_W = 5;

  localparam logic [ALUSEL_W-1:0] ALUSEL_ADD    = 5'd0;
  localparam logic [ALUSEL_W-1:0] ALUSEL_SUB    = 5'd1;
  localparam logic [ALUSEL_W-1:0] ALUSEL_MUL    = 5'd10;
  localparam logic [ALUSEL_W-1:0] ALUSEL_MULH   = 5'd11;
  localparam logic [ALUSEL_W-1:0] ALUSEL_MULHSU = 5'd12;
  localparam logic [ALUSEL_W-1:0] ALUSEL_MULHU  = 5'd13;

  typedef enum logic [1:0] {
    MUL_ST_IDLE = 2'd0,
    MUL_ST_CALC = 2'd1,
    MUL_ST_DONE = 2'd2
  } mul_state_e;

  function automatic logic is_mul_op(input logic [ALUSEL_W-1:0] sel);
    return (sel == ALUSEL_MUL) || (sel == ALUSEL_MULH) ||
           (sel == ALUSEL_MULHSU) || (sel == ALUSEL_MULHU);
  endfunction

endpackage

// File: rtl/mul_unit_abs.sv
// Conditional two's-complement negate: returns |value| and its sign, with an
// extra force-negate input so the same block can apply the product sign.
module mul_unit_abs #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value_i,
  input  logic             is_signed_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] mag_o,
  output logic             sign_o
);

  logic negate;

  always_comb begin
    sign_o = is_signed_i & value_i[WIDTH-1];
    negate = sign_o | neg_i;
    mag_o  = negate ? (~value_i + 1'b1) : value_i;
  end

endmodule

// File: rtl/mul_unit.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes on accept; the sign is restored in DONE.
module mul_unit
  import mul_unit_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [ALUSEL_W-1:0] alusel_i,
  input  logic [XLEN-1:0]     op_a_i,
  input  logic [XLEN-1:0]     op_b_i,
  input  logic                flush_i,
  output logic                busy_o,
  output logic                valid_o,
  output logic [XLEN-1:0]     result_o
);

  mul_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]       mcand_q, mcand_d;
  logic [XLEN-1:0]       mplier_q, mplier_d;
  logic [ALUSEL_W-1:0]   op_q, op_d;
  logic                  neg_q, neg_d;
  logic                  valid_q, valid_d;
  logic [XLEN-1:0]       result_q, result_d;

  logic                  a_signed, b_signed;
  logic [XLEN-1:0]       a_mag, b_mag;
  logic                  a_sign, b_sign;
  logic [2*XLEN-1:0]     product;
  logic                  prod_sign_unused;

  assign a_signed = (alusel_i != ALUSEL_MULHU);
  assign b_signed = (alusel_i == ALUSEL_MUL) || (alusel_i == ALUSEL_MULH);

  mul_unit_abs #(.WIDTH(XLEN)) u_abs_a (
    .value_i(op_a_i), .is_signed_i(a_signed), .neg_i(1'b0),
    .mag_o(a_mag), .sign_o(a_sign)
  );

  mul_unit_abs #(.WIDTH(XLEN)) u_abs_b (
    .value_i(op_b_i), .is_signed_i(b_signed), .neg_i(1'b0),
    .mag_o(b_mag), .sign_o(b_sign)
  );

  // Only neg_q decides the final negate; the accumulator MSB is not a sign.
  mul_unit_abs #(.WIDTH(2*XLEN)) u_abs_prod (
    .value_i(acc_q), .is_signed_i(1'b0), .neg_i(neg_q),
    .mag_o(product), .sign_o(prod_sign_unused)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    op_d     = op_q;
    neg_d    = neg_q;
    valid_d  = 1'b0;
    result_d = result_q;

    case (state_q)
      MUL_ST_IDLE: begin
        if (start_i && !flush_i && is_mul_op(alusel_i)) begin
          state_d  = MUL_ST_CALC;
          cnt_d    = '0;
          acc_d    = '0;
          op_d     = alusel_i;
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = a_sign ^ b_sign;
        end
      end
      MUL_ST_CALC: begin
        if (flush_i) begin
          state_d = MUL_ST_IDLE;
        end else begin
          if (mplier_q[0]) acc_d = acc_q + ({{XLEN{1'b0}}, mcand_q} << cnt_q);
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_d = MUL_ST_DONE;
        end
      end
      MUL_ST_DONE: begin
        state_d = MUL_ST_IDLE;
        if (!flush_i) begin
          valid_d  = 1'b1;
          result_d = (op_q == ALUSEL_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
        end
      end
      default: state_d = MUL_ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MUL_ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign busy_o   = (state_q != MUL_ST_IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: vector table for results and latency, plus
// hand-written sequences for illegal op, busy restart, flush and async reset.
module tb_mul_unit;
  import mul_unit_pkg::*;

  localparam int XLEN = 32;
  localparam int LAT  = XLEN + 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start_i;
  logic [ALUSEL_W-1:0] alusel_i;
  logic [XLEN-1:0]     op_a_i, op_b_i;
  logic                flush_i;
  logic                busy_o, valid_o;
  logic [XLEN-1:0]     result_o;

  int n_total = 0;
  int n_pass  = 0;

  mul_unit #(.XLEN(XLEN), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .alusel_i(alusel_i),
    .op_a_i(op_a_i), .op_b_i(op_b_i), .flush_i(flush_i),
    .busy_o(busy_o), .valid_o(valid_o), .result_o(result_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string               name;
    logic [ALUSEL_W-1:0] op;
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic [XLEN-1:0]     exp;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Drives a request in the current cycle and returns #1 after the accepting edge.
  task automatic launch(input logic [ALUSEL_W-1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    start_i  = 1'b1;
    alusel_i = op;
    op_a_i   = a;
    op_b_i   = b;
    @(posedge clk); #1;
    start_i  = 1'b0;
  endtask

  // c0 is the cycle index (relative to the accept edge) at entry.
  task automatic wait_result(input string name, input logic [XLEN-1:0] exp, input int c0);
    int  c = c0;
    bit  busy_ok = 1'b1;
    while (!valid_o && c < LAT + 20) begin
      if (!busy_o) busy_ok = 1'b0;
      @(posedge clk); #1;
      c++;
    end
    check({name, " valid_seen"}, 32'(valid_o), 32'd1);
    check({name, " latency"}, 32'(c), 32'(LAT));
    check({name, " busy_during"}, 32'(busy_ok), 32'd1);
    check({name, " busy_at_valid"}, 32'(busy_o), 32'd0);
    check({name, " result"}, result_o, exp);
  endtask

  initial begin
    logic [XLEN-1:0] held;
    bit              seen;

    vecs[0] = '{"mul_7x6",        ALUSEL_MUL,    32'd7,        32'd6,        32'h0000002A};
    vecs[1] = '{"mulh_min_min",   ALUSEL_MULH,   32'h80000000, 32'h80000000, 32'h40000000};
    vecs[2] = '{"mulh_m1_m1",     ALUSEL_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    vecs[3] = '{"mulhu_max_max",  ALUSEL_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[4] = '{"mulhsu_m1_2",    ALUSEL_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF};
    vecs[5] = '{"mul_m3_5",       ALUSEL_MUL,    32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1};
    vecs[6] = '{"mulh_max_min",   ALUSEL_MULH,   32'h7FFFFFFF, 32'h80000000, 32'hC0000000};
    vecs[7] = '{"mulhu_min_2",    ALUSEL_MULHU,  32'h80000000, 32'd2,        32'h00000001};
    vecs[8] = '{"mulhsu_min_max", ALUSEL_MULHSU, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    vecs[9] = '{"mul_m1_m1",      ALUSEL_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};

    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0;
    alusel_i = ALUSEL_ADD; op_a_i = '0; op_b_i = '0;
    #12;
    check("reset busy",   32'(busy_o),  32'd0);
    check("reset valid",  32'(valid_o), 32'd0);
    check("reset result", result_o,     32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Each vector starts in the valid cycle of the previous one (back-to-back).
    for (int i = 0; i < 10; i++) begin
      launch(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_result(vecs[i].name, vecs[i].exp, 1);
    end
    @(posedge clk); #1;
    check("valid single pulse", 32'(valid_o), 32'd0);
    check("result held", result_o, 32'h00000001);

    // Non-multiply op is ignored.
    launch(ALUSEL_ADD, 32'd3, 32'd4);
    seen = 1'b0;
    for (int i = 0; i < LAT + 4; i++) begin
      if (busy_o || valid_o) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("illegal op ignored", 32'(seen), 32'd0);

    // Restart attempt during CALC is dropped.
    launch(ALUSEL_MUL, 32'd3, 32'd5);
    repeat (4) begin @(posedge clk); #1; end
    launch(ALUSEL_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    alusel_i = ALUSEL_MULHU; op_a_i = 32'hDEADBEEF; op_b_i = 32'h12345678;
    wait_result("start_while_busy", 32'h0000000F, 6);
    @(posedge clk); #1;

    // Flush at CALC cycle 10: back to IDLE, no pulse, result kept.
    held = result_o;
    launch(ALUSEL_MUL, 32'd9, 32'd9);
    repeat (9) begin @(posedge clk); #1; end
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush busy low", 32'(busy_o), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      if (valid_o || busy_o) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("flush no valid", 32'(seen), 32'd0);
    check("flush result kept", result_o, held);

    // Flush together with start in IDLE: nothing accepted.
    flush_i = 1'b1;
    launch(ALUSEL_MUL, 32'd2, 32'd2);
    flush_i = 1'b0;
    check("flush beats start", 32'(busy_o), 32'd0);

    launch(ALUSEL_MUL, 32'd3, 32'd5);
    wait_result("mul_after_flush", 32'h0000000F, 1);
    @(posedge clk); #1;

    // Asynchronous reset at CALC cycle 20, observed before any clock edge.
    launch(ALUSEL_MUL, 32'h00012345, 32'h00000100);
    repeat (19) begin @(posedge clk); #1; end
    #1 rst_n = 1'b0;
    #1;
    check("async rst busy",   32'(busy_o),  32'd0);
    check("async rst valid",  32'(valid_o), 32'd0);
    check("async rst result", result_o,     32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post reset idle", 32'(busy_o), 32'd0);
    launch(ALUSEL_MUL, 32'h00012345, 32'h00000100);
    wait_result("mul_after_reset", 32'h01234500, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Iterative radix-2 shift-add multiplier for the RV32M multiply group: MUL, MULH, MULHSU, MULHU.
- Sits downstream of the control decoder and consumes its ALU-select code together with the two operand-mux outputs.
- Executes as a multi-cycle unit beside the single-cycle ALU. The pipeline stalls on busy_o and captures result_o on valid_o.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 5, iteration counter width; must equal log2(XLEN).

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request; sampled only in IDLE.
- alusel_i  input  `ALUSEL_BUS  operation code from the control decoder.
- op_a_i  input  XLEN  rs1 / A-mux operand.
- op_b_i  input  XLEN  rs2 / B-mux operand.
- flush_i  input  1  abort the current operation (branch/jump redirect).
- busy_o  output  1  operation in progress; the pipeline stalls while high.
- valid_o  output  1  single-cycle pulse; result_o is valid in that cycle.
- result_o  output  XLEN  selected product word; held until the next accepted start.

Behaviour:
- Reset, asynchronous while rst_n=0:
  - State is IDLE.
  - busy_o=0, valid_o=0, result_o=0.
  - Counter and accumulator are 0.
  - Takes effect immediately, including mid-operation. After release the unit is in IDLE.
- Accept condition: state==IDLE && start_i && alusel_i in {ALUSEL_MUL, ALUSEL_MULH, ALUSEL_MULHSU, ALUSEL_MULHU}.
  - Any other alusel_i with start_i is ignored: no state change, busy_o stays 0.
- On accept, latch:
  - op code;
  - |op_a| (signed for MUL, MULH, MULHSU);
  - |op_b| (signed for MUL, MULH);
  - neg = sign_a XOR sign_b, counting only the signed operands.
  - MUL low word is sign-independent; the signed path is used anyway for uniformity.
- State machine, 3 states:
  - IDLE --accept--> CALC. counter=0, acc[2*XLEN-1:0]=0.
  - CALC: each cycle, if multiplier LSB=1 then acc += multiplicand << counter. Multiplier shifts right by 1; counter increments.
    - After iteration XLEN-1 (counter==XLEN-1), go to DONE.
    - Exactly XLEN CALC cycles.
  - DONE: product = neg ? -acc : acc, computed in 2*XLEN bits, two's complement.
    - result_o <= product[XLEN-1:0] for MUL; product[2*XLEN-1:XLEN] for MULH, MULHSU, MULHU.
    - Next state is IDLE.
  - valid_o=1 for exactly the cycle after DONE, registered with result_o.
- busy_o:
  - 1 from the cycle after accept up to and including the DONE cycle.
  - 0 in the valid_o cycle, so the stalled instruction retires in that cycle.
- Latency: start accepted at edge N gives valid_o high in cycle N+XLEN+2 (34 cycles for XLEN=32).
- Back-to-back: start_i in the valid_o cycle is accepted, since the state is IDLE.
- Start while busy: ignored, not queued.
- flush_i:
  - In CALC or DONE: next state IDLE, busy_o=0, no valid_o pulse, result_o unchanged.
  - flush_i together with start_i in IDLE: the flush wins and nothing is accepted.
- Operands are sampled only on accept. Input changes while busy have no effect.
- Overflow: none possible; the 2*XLEN accumulator holds any XLEN x XLEN magnitude product.
  - The -2^31 operand magnitude is 2^31 and is representable as unsigned XLEN.

Decomposition:
- Existing core_param.v supplies `ALUSEL_BUS and ALUSEL_MUL, ALUSEL_MULH, ALUSEL_MULHSU, ALUSEL_MULHU.
- Add the state encodings MUL_ST_IDLE, MUL_ST_CALC, MUL_ST_DONE to core_param.v.
- One sub-module is natural: mul_abs, a combinational conditional negate producing {magnitude, sign} from (value, is_signed).
  - Instantiate it twice for the operands.
  - The DONE-stage conditional negate reuses the same logic at 2*XLEN width via a WIDTH parameter.

Test Plan:
- MUL, a=7, b=6, start at cycle 0 -> busy_o cycles 1..33, valid_o at cycle 34, result_o=0x0000002A.
- MULH, a=0x80000000, b=0x80000000 -> result_o=0x40000000. MULH, a=0xFFFFFFFF, b=0xFFFFFFFF -> result_o=0x00000000.
- MULHU, a=0xFFFFFFFF, b=0xFFFFFFFF -> result_o=0xFFFFFFFE. MULHSU, a=0xFFFFFFFF (-1), b=2 -> result_o=0xFFFFFFFF.
- Start with alusel_i=ALUSEL_ADD -> busy_o stays 0, no valid_o. Start during CALC with new operands -> ignored; the original result is delivered.
- MUL 3*5 with flush_i at CALC cycle 10 -> IDLE the next cycle, no valid_o, result_o keeps its old value. A following MUL 3*5 -> 0x0000000F at the normal latency.
- rst_n low at CALC cycle 20 -> busy_o, valid_o and result_o go to 0 immediately, without a clock edge. Start after release -> correct result, full latency.
